i2c_target: RTL and testbench

I2C target (responder) for the serial I2C subsystem. It is the other end of the bus from the `I2C_Controller` initiator. It oversamples `scl`/`sda` on the system clock, detects START, repeated START and STOP, and matches a 7-bit address. It then streams write bytes out over a valid/ready port and read bytes in over a valid/ready port, driving `sda` open-drain for ACK and read data. It never drives `scl`: no clock stretching.

---
 rtl/i2c_target.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with 7-bit address match.
// Oversamples scl/sda on clk, detects START / repeated START / STOP, streams
// written bytes out on rx_* and fetches read bytes on tx_*. sda is driven
// open-drain through sda_oen. scl is never driven, so there is no clock stretching.
module i2c_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oen,
    input  logic [6:0] cfg_address,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rw,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Bus sampling and condition detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_cur;
    logic                   sda_cur;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_cond;
    logic                   stop_cond;

    // Synchronise both pins, then keep one sample of history for edge detection.
    // Everything resets to the idle (pulled-up) level so reset creates no edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    assign scl_cur  = scl_sync_reg[SYNC_STAGES-1];
    assign sda_cur  = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise = ~scl_prev_reg & scl_cur;
    assign scl_fall = scl_prev_reg & ~scl_cur;

    // Requiring scl high in both samples means an scl edge in the same sample
    // as an sda edge suppresses START/STOP.
    assign start_cond = scl_prev_reg & scl_cur & sda_prev_reg & ~sda_cur;
    assign stop_cond  = scl_prev_reg & scl_cur & ~sda_prev_reg & sda_cur;

    // ------------------------------------------------------------------
    // Protocol state machine
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    // Per-state phase flag: ADDR_ACK = ACK slot entered, WR_DATA = byte
    // complete, RD_ACK = initiator ACK seen.
    logic       slot_reg, slot_next;
    logic       sda_oen_reg, sda_oen_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_ready_reg, tx_ready_next;
    logic       rw_reg, rw_next;
    logic       busy_reg, busy_next;
    logic       start_det_reg, start_det_next;
    logic       stop_det_reg, stop_det_next;
    logic       error_reg, error_next;

    logic [7:0] shift_in;
    logic [7:0] load_byte;

    assign shift_in  = {shift_reg[6:0], sda_cur};
    // Underrun returns all ones, which leaves sda released for the whole byte
    assign load_byte = tx_valid ? tx_data : 8'hFF;

    // State and datapath registers; reset releases sda immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            slot_reg      <= 1'b0;
            sda_oen_reg   <= 1'b1;
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            tx_ready_reg  <= 1'b0;
            rw_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            slot_reg      <= slot_next;
            sda_oen_reg   <= sda_oen_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            tx_ready_reg  <= tx_ready_next;
            rw_reg        <= rw_next;
            busy_reg      <= busy_next;
            start_det_reg <= start_det_next;
            stop_det_reg  <= stop_det_next;
            error_reg     <= error_next;
        end
    end

    // Next-state and output decode; START/STOP override every state
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        slot_next      = slot_reg;
        sda_oen_next   = sda_oen_reg;
        rx_data_next   = rx_data_reg;
        rw_next        = rw_reg;
        busy_next      = busy_reg;
        rx_valid_next  = 1'b0;
        tx_ready_next  = 1'b0;
        start_det_next = 1'b0;
        stop_det_next  = 1'b0;
        error_next     = 1'b0;

        if (start_cond) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            slot_next      = 1'b0;
            sda_oen_next   = 1'b1;
            busy_next      = 1'b0;
            start_det_next = 1'b1;
        end else if (stop_cond) begin
            state_next    = IDLE;
            slot_next     = 1'b0;
            sda_oen_next  = 1'b1;
            busy_next     = 1'b0;
            stop_det_next = 1'b1;
        end else begin
            case (state_reg)
                IDLE, IGNORE: begin
                    sda_oen_next = 1'b1;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (shift_in[7:1] == cfg_address) begin
                                rw_next    = shift_in[0];
                                busy_next  = 1'b1;
                                slot_next  = 1'b0;
                                state_next = ADDR_ACK;
                            end else begin
                                state_next = IGNORE;
                            end
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!slot_reg) begin
                            // Fall after the R/W bit: open the ACK slot
                            sda_oen_next = 1'b0;
                            slot_next    = 1'b1;
                        end else begin
                            // Fall closing the ACK slot
                            slot_next    = 1'b0;
                            bit_cnt_next = 3'd0;
                            if (rw_reg) begin
                                tx_ready_next = 1'b1;
                                shift_next    = load_byte;
                                sda_oen_next  = load_byte[7];
                                error_next    = ~tx_valid;
                                state_next    = RD_DATA;
                            end else begin
                                sda_oen_next = 1'b1;
                                state_next   = WR_DATA;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise && !slot_reg) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            slot_next = 1'b1;
                        end
                    end else if (scl_fall && slot_reg) begin
                        // Byte complete: hand it over and decide ACK/NACK
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                        sda_oen_next  = ~rx_ready;
                        error_next    = ~rx_ready;
                        slot_next     = 1'b0;
                        bit_cnt_next  = 3'd0;
                        state_next    = WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oen_next = 1'b1;
                        state_next   = WR_DATA;
                    end
                end

                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd7) begin
                            // Bit 0 finished: release for the initiator's ACK
                            sda_oen_next = 1'b1;
                            bit_cnt_next = 3'd0;
                            slot_next    = 1'b0;
                            state_next   = RD_ACK;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b1};
                            sda_oen_next = shift_reg[6];
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_cur) begin
                            // NACK ends the read
                            busy_next    = 1'b0;
                            sda_oen_next = 1'b1;
                            state_next   = IGNORE;
                        end else begin
                            slot_next = 1'b1;
                        end
                    end else if (scl_fall && slot_reg) begin
                        slot_next     = 1'b0;
                        bit_cnt_next  = 3'd0;
                        tx_ready_next = 1'b1;
                        shift_next    = load_byte;
                        sda_oen_next  = load_byte[7];
                        error_next    = ~tx_valid;
                        state_next    = RD_DATA;
                    end
                end
            endcase
        end
    end

    assign sda_oen   = sda_oen_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign tx_ready  = tx_ready_reg;
    assign rw        = rw_reg;
    assign busy      = busy_reg;
    assign start_det = start_det_reg;
    assign stop_det  = stop_det_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-level initiator drives scl/sda, a transaction
// model queues the expected responses, and two monitors pop and compare them.
module tb_i2c_target;

    localparam int H = 12;  // clk cycles per SCL half period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_oen;
    wire        sda_line = sda_m & sda_oen;
    logic [6:0] cfg_address;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rw;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       error;

    always #5 clk = ~clk;

    i2c_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oen(sda_oen),
        .cfg_address(cfg_address), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rw(rw), .busy(busy), .start_det(start_det),
        .stop_det(stop_det), .error(error)
    );

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard queues
    logic [8:0] exp_rx_q[$];   // {expected error, expected rx_data}
    logic       tx_req_q[$];   // expected error on each tx_ready
    logic [8:0] tx_src_q[$];   // {tx_valid, tx_data} offered to the target
    logic       exp_bit_q[$];  // expected sda level in target-owned slots
    int         exp_start = 0;
    int         exp_stop = 0;
    logic       slave_slot = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse monitor; also presents the front of the tx source queue
    initial begin
        logic [8:0] e;
        logic       ee;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) check1("unexpected_rx_valid", rx_valid, 1'b0);
                else begin
                    e = exp_rx_q.pop_front();
                    check8("rx_data", rx_data, e[7:0]);
                    check1("rx_error", error, e[8]);
                    $display("rx byte %02h error=%b", rx_data, error);
                end
            end
            if (tx_ready) begin
                if (tx_req_q.size() == 0) check1("unexpected_tx_ready", tx_ready, 1'b0);
                else begin
                    ee = tx_req_q.pop_front();
                    check1("tx_error", error, ee);
                    $display("tx request served data=%02h valid=%b", tx_data, tx_valid);
                end
                if (tx_src_q.size() != 0) void'(tx_src_q.pop_front());
            end
            if (error && !rx_valid && !tx_ready) check1("spurious_error", error, 1'b0);
            if (start_det) begin
                if (exp_start == 0) check1("unexpected_start_det", start_det, 1'b0);
                else exp_start--;
            end
            if (stop_det) begin
                if (exp_stop == 0) check1("unexpected_stop_det", stop_det, 1'b0);
                else exp_stop--;
            end
            if (tx_src_q.size() != 0) begin
                tx_valid = tx_src_q[0][8];
                tx_data  = tx_src_q[0][7:0];
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        end
    end

    // Bit monitor: samples sda mid-high in every target-owned slot
    initial begin
        logic b;
        forever begin
            @(posedge scl);
            repeat (6) @(negedge clk);
            if (slave_slot) begin
                if (exp_bit_q.size() == 0) check1("unexpected_slot", slave_slot, 1'b0);
                else begin
                    b = exp_bit_q.pop_front();
                    check1("sda_bit", sda_line, b);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        exp_start++;
        tick(3); sda_m = 1'b1;
        tick(H - 3); scl = 1'b1;
        tick(H); sda_m = 1'b0;
        tick(H); scl = 1'b0;
    endtask

    task automatic bus_stop();
        exp_stop++;
        tick(3); sda_m = 1'b0;
        tick(H - 3); scl = 1'b1;
        tick(H); sda_m = 1'b1;
        tick(H);
        check_int("stop_det_seen", exp_stop, 0);
        check1("busy_after_stop", busy, 1'b0);
    endtask

    task automatic master_bit(input logic b);
        tick(3); sda_m = b;
        tick(H - 3); scl = 1'b1;
        tick(H); scl = 1'b0;
    endtask

    task automatic slave_bit(input logic exp);
        tick(3); sda_m = 1'b1;
        exp_bit_q.push_back(exp);
        slave_slot = 1'b1;
        tick(H - 3); scl = 1'b1;
        tick(H); scl = 1'b0;
        slave_slot = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_level);
        for (int i = 7; i >= 0; i--) master_bit(b[i]);
        slave_bit(ack_level);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic nack);
        for (int i = 7; i >= 0; i--) slave_bit(exp[i]);
        master_bit(nack);
    endtask

    // Write transaction model: the addressed target ACKs each byte iff the
    // sink was ready, and every byte surfaces on rx_* regardless.
    task automatic xfer_write(input logic [6:0] addr, input int n, input logic [31:0] data,
                              input logic [3:0] rdy, input bit do_stop);
        bit         match;
        logic [7:0] b;
        match = (addr == cfg_address);
        $display("write addr=%02h cfg=%02h n=%0d data=%08h rdy=%b", addr, cfg_address, n, data, rdy);
        bus_start();
        send_byte({addr, 1'b0}, !match);
        check_int("start_det_seen", exp_start, 0);
        check1("busy_after_addr", busy, match);
        if (match) check1("rw_write", rw, 1'b0);
        for (int k = 0; k < n; k++) begin
            b = data[8*k +: 8];
            rx_ready = rdy[k];
            if (match) exp_rx_q.push_back({~rdy[k], b});
            send_byte(b, !(match && rdy[k]));
        end
        check_int("rx_drain", exp_rx_q.size(), 0);
        if (do_stop) bus_stop();
    endtask

    // Read transaction model: target returns each offered byte, or 8'hFF when
    // none was offered; the initiator ACKs all but the last byte.
    task automatic xfer_read(input logic [6:0] addr, input int n, input logic [31:0] data,
                             input logic [3:0] valid, input bit do_stop);
        bit         match;
        logic [7:0] b;
        match = (addr == cfg_address);
        $display("read addr=%02h cfg=%02h n=%0d data=%08h valid=%b", addr, cfg_address, n, data, valid);
        if (match) begin
            for (int k = 0; k < n; k++) begin
                tx_src_q.push_back({valid[k], data[8*k +: 8]});
                tx_req_q.push_back(~valid[k]);
            end
        end
        bus_start();
        send_byte({addr, 1'b1}, !match);
        check_int("start_det_seen", exp_start, 0);
        check1("busy_after_addr", busy, match);
        if (match) check1("rw_read", rw, 1'b1);
        for (int k = 0; k < n; k++) begin
            b = (match && valid[k]) ? data[8*k +: 8] : 8'hFF;
            recv_byte(b, k == n - 1);
        end
        if (match) check1("busy_after_nack", busy, 1'b0);
        check_int("tx_req_drain", tx_req_q.size(), 0);
        check_int("bit_drain", exp_bit_q.size(), 0);
        if (do_stop) bus_stop();
    endtask

    initial begin
        logic [6:0]  a;
        logic [31:0] d;
        logic [3:0]  m;
        int          n;

        rst = 1'b1;
        scl = 1'b1;
        sda_m = 1'b1;
        rx_ready = 1'b1;
        cfg_address = 7'h42;
        tick(5);
        rst = 1'b0;
        tick(3);

        check1("reset_sda_oen", sda_oen, 1'b1);
        check8("reset_rx_data", rx_data, 8'h00);
        check1("reset_rx_valid", rx_valid, 1'b0);
        check1("reset_tx_ready", tx_ready, 1'b0);
        check1("reset_rw", rw, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_error", error, 1'b0);

        // Directed cases
        xfer_write(7'h42, 1, 32'h0000_00A5, 4'hF, 1'b1);
        check8("rx_data_holds", rx_data, 8'hA5);
        xfer_write(7'h43, 2, 32'h0000_1234, 4'hF, 1'b1);
        xfer_read(7'h42, 2, 32'h0000_C33C, 4'h3, 1'b1);
        xfer_write(7'h42, 2, 32'h0000_775A, 4'b0010, 1'b1);
        xfer_read(7'h42, 1, 32'h0000_0012, 4'h0, 1'b1);
        xfer_write(7'h42, 1, 32'h0000_0099, 4'hF, 1'b0);
        xfer_read(7'h42, 1, 32'h0000_005E, 4'hF, 1'b1);

        // Randomised transactions
        for (int t = 0; t < 14; t++) begin
            cfg_address = 7'($urandom_range(0, 127));
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : cfg_address;
            n = int'($urandom_range(1, 3));
            d = $urandom();
            m = 4'($urandom() | $urandom());
            if ($urandom_range(0, 1) == 1) xfer_write(a, n, d, m, 1'b1);
            else xfer_read(a, n, d, m, 1'b1);
        end

        // Reset in the middle of a read byte of zeros
        cfg_address = 7'h42;
        $display("reset mid-read");
        tx_src_q.push_back({1'b1, 8'h00});
        tx_req_q.push_back(1'b0);
        bus_start();
        send_byte({7'h42, 1'b1}, 1'b0);
        slave_bit(1'b0);
        slave_bit(1'b0);
        slave_bit(1'b0);
        tick(H / 2);
        check1("oen_before_rst", sda_oen, 1'b0);
        rst = 1'b1;
        #1;
        check1("oen_in_rst", sda_oen, 1'b1);
        check1("busy_in_rst", busy, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(H / 2 - 3);
        scl = 1'b1;
        tick(H);
        scl = 1'b0;
        for (int i = 0; i < 4; i++) slave_bit(1'b1);
        master_bit(1'b1);
        bus_stop();
        xfer_write(7'h42, 1, 32'h0000_005A, 4'hF, 1'b1);

        check_int("final_rx_drain", exp_rx_q.size(), 0);
        check_int("final_tx_drain", tx_req_q.size(), 0);
        check_int("final_bit_drain", exp_bit_q.size(), 0);
        check_int("final_start_drain", exp_start, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
